// File: rtl/apa102_pkg.sv
// Shared APA102 framing constants, streamer FSM states and end-frame length helper.
package apa102_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_FRM,
        FETCH,
        WAIT,
        LED_FRM,
        END_FRM,
        DONE
    } apa102_state_t;

    localparam logic [2:0] APA102_HDR        = 3'b111;
    localparam int         APA102_START_BITS = 32;
    localparam int         APA102_FRAME_BITS = 32;

    // One extra SCK edge per two LEDs pushes data through the strip; rounded to 32-bit words.
    function automatic int apa102_end_bits(input int num_leds);
        return 32 * ((num_leds + 63) / 64);
    endfunction

endpackage

// File: rtl/sck_bit_gen.sv
// SCK half-period divider: produces led_sck plus rise / bit_done ticks.
// Latency: sck toggles CLK_DIV cycles after enable; no backpressure, clr restarts a bit.
// Ticks are combinational and asserted in the cycle before the corresponding sck edge.
module sck_bit_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic sck,
    output logic rise,
    output logic bit_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          half_end;

    assign half_end = en && (cnt == CW'(CLK_DIV - 1));
    assign rise     = half_end && !sck;
    assign bit_done = half_end && sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (en) begin
            if (half_end) begin
                cnt <= '0;
                sck <= ~sck;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/apa102_column_streamer.sv
// Streams one column of frame-RAM pixels to an APA102 strip; APA102_STREAMER_BRIGHTNESS_EN takes brightness from ram_rdata[28:24].
// Latency: busy for 2*CLK_DIV*(32+32*NUM_LEDS+END_BITS)+2*NUM_LEDS+1 cycles, done pulses as busy falls.
// Backpressure: none; start is ignored while busy and in the done cycle.
module apa102_column_streamer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int NUM_LEDS      = 52,
    parameter int CLK_DIV       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     led_sck,
    output logic                     led_sdi
);

    import apa102_pkg::*;

    localparam int END_BITS = apa102_end_bits(NUM_LEDS);
    localparam int MAX_BITS = (END_BITS > APA102_FRAME_BITS) ? END_BITS : APA102_FRAME_BITS;
    localparam int BC_W     = $clog2(MAX_BITS);
    localparam int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    apa102_state_t                  state, state_nxt;
    logic [ADDRESS_WIDTH-1:0]       base_q;
    logic [IDX_W-1:0]               idx;
    logic [BC_W-1:0]                bit_cnt, last_idx;
    logic [APA102_FRAME_BITS-1:0]   sreg, pixel;
    logic [4:0]                     bright;
    logic                           shift_en, enter, last_bit, bit_done;
    logic                           unused_rise, unused_rdata;

    assign unused_rdata = ^ram_rdata;

`ifdef APA102_STREAMER_BRIGHTNESS_EN
    assign bright = ram_rdata[28:24];
`else
    assign bright = 5'h1F;
`endif

    assign pixel    = {APA102_HDR, bright, ram_rdata[7:0], ram_rdata[15:8], ram_rdata[23:16]};
    assign last_bit = (bit_cnt == last_idx);
    assign led_sdi  = sreg[APA102_FRAME_BITS-1];

    sck_bit_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (shift_en),
        .clr      (enter),
        .sck      (led_sck),
        .rise     (unused_rise),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The done cycle is already IDLE, so start must also be masked by done there.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start && !done) state_nxt = START_FRM;
            START_FRM: if (bit_done && last_bit) state_nxt = FETCH;
            FETCH:     state_nxt = WAIT;
            WAIT:      state_nxt = LED_FRM;
            LED_FRM:   if (bit_done && last_bit)
                           state_nxt = (idx == IDX_W'(NUM_LEDS - 1)) ? END_FRM : FETCH;
            END_FRM:   if (bit_done && last_bit) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        shift_en = (state == START_FRM) || (state == LED_FRM) || (state == END_FRM);
        enter    = (state_nxt != state);
        case (state)
            START_FRM: last_idx = BC_W'(APA102_START_BITS - 1);
            END_FRM:   last_idx = BC_W'(END_BITS - 1);
            default:   last_idx = BC_W'(APA102_FRAME_BITS - 1);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            idx      <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            ram_addr <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == IDLE && state_nxt == START_FRM) begin
                base_q <= base_addr;
                idx    <= '0;
            end else if (state == LED_FRM && state_nxt != LED_FRM) begin
                idx <= idx + 1'b1;
            end
            // Address for the next pixel is issued on the FETCH entry edge, ahead of the idx update.
            if (state_nxt == FETCH && state != FETCH)
                ram_addr <= base_q + ADDRESS_WIDTH'((state == LED_FRM) ? idx + 1'b1 : idx);
            if (enter)         bit_cnt <= '0;
            else if (bit_done) bit_cnt <= bit_cnt + 1'b1;
            // The last bit of each frame is left on sdi through FETCH/WAIT.
            if (enter && state_nxt == LED_FRM)
                sreg <= pixel;
            else if (enter && state_nxt == END_FRM)
                sreg <= '1;
            else if (enter && (state_nxt == START_FRM || state_nxt == DONE))
                sreg <= '0;
            else if (bit_done && !last_bit)
                sreg <= {sreg[APA102_FRAME_BITS-2:0], (state == END_FRM)};
        end
    end

endmodule
